ex_mem_stage: RTL

- EX/MEM pipeline register directly downstream of the 32-bit ALU.
- Captures aluout, compout and overflow together with the execute-stage control bundle, and presents them to the memory stage.
- Applies stall and flush, and converts signed-arithmetic overflow into a precise exception.
- Once an exception is raised, the block squashes every following instruction until the exception is acknowledged.

---
 rtl/ex_mem_stage_pkg.sv | 33 +++
 rtl/ex_mem_stage_if.sv | 49 ++++
 rtl/ex_mem_exc_ctrl.sv | 115 +++++++++++
 rtl/ex_mem_stage.sv | 124 ++++++++++++
 4 files changed

// File: rtl/ex_mem_stage_pkg.sv
// ex_mem_stage_pkg
// Shared definitions for the EX/MEM pipeline register: default widths,
// the overflow cause code, exception FSM state encoding and the
// memory-stage control bundle.
package ex_mem_stage_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_CNT_W      = 8;
  localparam int CAUSE_W        = 5;
  localparam int CTRL_W         = 4;

  // Cause code reported for a signed-arithmetic overflow trap.
  localparam logic [CAUSE_W-1:0] EXC_OVF = 5'd12;

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_DRAIN  = 1'b1
  } exc_state_e;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic memtoreg;
  } ctrl_t;

  // A control bit only takes effect for a real instruction.
  function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic valid);
    gate_ctrl = c & {CTRL_W{valid}};
  endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// ex_mem_stage_if
// Bundle between the execute stage, the EX/MEM register and the memory stage.
//   ex_*  : execute-stage instruction (driven by master, read by slave)
//   mem_* : registered memory-stage instruction (driven by slave)
// Modports: master = upstream/stimulus side, slave = the pipeline register.
interface ex_mem_stage_if
  import ex_mem_stage_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
);
  logic                  ex_valid;
  logic [DATA_W-1:0]     ex_aluout;
  logic                  ex_compout;
  logic                  ex_overflow;
  logic                  ex_ovf_en;
  logic [DATA_W-1:0]     ex_pc;
  logic [DATA_W-1:0]     ex_wdata;
  logic [REG_ADDR_W-1:0] ex_regdst;
  logic                  ex_regwrite;
  logic                  ex_memread;
  logic                  ex_memwrite;
  logic                  ex_memtoreg;

  logic                  mem_valid;
  logic [DATA_W-1:0]     mem_aluout;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_compout;
  logic [REG_ADDR_W-1:0] mem_regdst;
  logic                  mem_regwrite;
  logic                  mem_memread;
  logic                  mem_memwrite;
  logic                  mem_memtoreg;

  modport master (
    output ex_valid, ex_aluout, ex_compout, ex_overflow, ex_ovf_en, ex_pc,
           ex_wdata, ex_regdst, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg,
    input  mem_valid, mem_aluout, mem_wdata, mem_compout, mem_regdst,
           mem_regwrite, mem_memread, mem_memwrite, mem_memtoreg
  );

  modport slave (
    input  ex_valid, ex_aluout, ex_compout, ex_overflow, ex_ovf_en, ex_pc,
           ex_wdata, ex_regdst, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg,
    output mem_valid, mem_aluout, mem_wdata, mem_compout, mem_regdst,
           mem_regwrite, mem_memread, mem_memwrite, mem_memtoreg
  );

endinterface

// File: rtl/ex_mem_exc_ctrl.sv
// ex_mem_exc_ctrl
// Overflow exception controller for the EX/MEM register.
// Ports:
//   clock, reset          : clock, async active-high reset
//   ex_valid/overflow/ovf_en, ex_pc : trap qualification and EPC source
//   stall, flush, exc_ack : pipeline control and exception acknowledge
//   load_bubble           : datapath must load a bubble on this edge
//   exc_valid/pending/pc/cause/count : registered exception reporting
module ex_mem_exc_ctrl
  import ex_mem_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ex_valid,
  input  logic               ex_overflow,
  input  logic               ex_ovf_en,
  input  logic [DATA_W-1:0]  ex_pc,
  input  logic               stall,
  input  logic               flush,
  input  logic               exc_ack,
  output logic               load_bubble,
  output logic               exc_valid,
  output logic               exc_pending,
  output logic [DATA_W-1:0]  exc_pc,
  output logic [CAUSE_W-1:0] exc_cause,
  output logic [CNT_W-1:0]   exc_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  exc_state_e         state_q, state_d;
  logic               exc_valid_q, exc_valid_d;
  logic [DATA_W-1:0]  exc_pc_q, exc_pc_d;
  logic [CAUSE_W-1:0] exc_cause_q, exc_cause_d;
  logic [CNT_W-1:0]   exc_count_q, exc_count_d;
  logic               trap;

  assign trap = ex_valid & ex_overflow & ex_ovf_en;

  // Next-state, exception capture and bubble strobe; flush > stall > trap.
  always_comb begin
    state_d     = state_q;
    exc_valid_d = 1'b0;
    exc_pc_d    = exc_pc_q;
    exc_cause_d = exc_cause_q;
    exc_count_d = exc_count_q;
    load_bubble = 1'b0;
    if (flush) begin
      load_bubble = 1'b1;
    end else if (stall) begin
      // Registers hold, but an acknowledge still releases DRAIN.
      if ((state_q == ST_DRAIN) && exc_ack) begin
        state_d = ST_NORMAL;
      end else begin
        state_d = state_q;
      end
    end else begin
      case (state_q)
        ST_NORMAL: begin
          if (trap) begin
            load_bubble = 1'b1;
            exc_valid_d = 1'b1;
            exc_pc_d    = ex_pc;
            exc_cause_d = EXC_OVF;
            exc_count_d = (exc_count_q == CNT_MAX) ? exc_count_q : exc_count_q + CNT_ONE;
            state_d     = ST_DRAIN;
          end else begin
            load_bubble = 1'b0;
          end
        end
        ST_DRAIN: begin
          // Squash everything, including the ack cycle itself.
          load_bubble = 1'b1;
          if (exc_ack) begin
            state_d = ST_NORMAL;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        default: begin
          load_bubble = 1'b1;
          state_d     = ST_NORMAL;
        end
      endcase
    end
  end

  // Exception state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_NORMAL;
      exc_valid_q <= 1'b0;
      exc_pc_q    <= {DATA_W{1'b0}};
      exc_cause_q <= {CAUSE_W{1'b0}};
      exc_count_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      exc_valid_q <= exc_valid_d;
      exc_pc_q    <= exc_pc_d;
      exc_cause_q <= exc_cause_d;
      exc_count_q <= exc_count_d;
    end
  end

  assign exc_valid   = exc_valid_q;
  assign exc_pending = (state_q == ST_DRAIN);
  assign exc_pc      = exc_pc_q;
  assign exc_cause   = exc_cause_q;
  assign exc_count   = exc_count_q;

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage
// EX/MEM pipeline register behind the ALU with stall, flush and precise
// overflow exceptions.
// Ports:
//   clock, reset     : clock, async active-high reset
//   bus (slave)      : ex_* inputs from execute, mem_* registered outputs
//   stall, flush     : hold registers / load a bubble
//   exc_ack          : controller has taken the pending exception
//   exc_*            : exception pulse, pending flag, EPC, cause, counter
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic               clock,
  input  logic               reset,
  ex_mem_stage_if.slave      bus,
  input  logic               stall,
  input  logic               flush,
  input  logic               exc_ack,
  output logic               exc_valid,
  output logic               exc_pending,
  output logic [DATA_W-1:0]  exc_pc,
  output logic [CAUSE_W-1:0] exc_cause,
  output logic [CNT_W-1:0]   exc_count
);

  logic load_bubble;
  logic hold;
  ctrl_t ex_ctrl;

  logic                  mem_valid_q, mem_valid_d;
  ctrl_t                 mem_ctrl_q, mem_ctrl_d;
  logic                  mem_compout_q, mem_compout_d;
  logic [DATA_W-1:0]     mem_aluout_q, mem_aluout_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic [REG_ADDR_W-1:0] mem_regdst_q, mem_regdst_d;

  ex_mem_exc_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_exc_ctrl (
    .clock       (clock),
    .reset       (reset),
    .ex_valid    (bus.ex_valid),
    .ex_overflow (bus.ex_overflow),
    .ex_ovf_en   (bus.ex_ovf_en),
    .ex_pc       (bus.ex_pc),
    .stall       (stall),
    .flush       (flush),
    .exc_ack     (exc_ack),
    .load_bubble (load_bubble),
    .exc_valid   (exc_valid),
    .exc_pending (exc_pending),
    .exc_pc      (exc_pc),
    .exc_cause   (exc_cause),
    .exc_count   (exc_count)
  );

  // Flush wins over stall, so a flushed stall still loads the bubble.
  assign hold = stall & ~flush;

  // Gather the execute-stage control bits into one bundle.
  always_comb begin
    ex_ctrl = '{regwrite: bus.ex_regwrite, memread: bus.ex_memread,
                memwrite: bus.ex_memwrite, memtoreg: bus.ex_memtoreg};
  end

  // Datapath next value: hold, bubble, or a normal load.
  always_comb begin
    mem_valid_d   = mem_valid_q;
    mem_ctrl_d    = mem_ctrl_q;
    mem_compout_d = mem_compout_q;
    mem_aluout_d  = mem_aluout_q;
    mem_wdata_d   = mem_wdata_q;
    mem_regdst_d  = mem_regdst_q;
    if (hold) begin
      mem_valid_d = mem_valid_q;
    end else if (load_bubble) begin
      mem_valid_d   = 1'b0;
      mem_ctrl_d    = '{default: 1'b0};
      mem_compout_d = 1'b0;
      mem_aluout_d  = {DATA_W{1'b0}};
      mem_wdata_d   = {DATA_W{1'b0}};
      mem_regdst_d  = {REG_ADDR_W{1'b0}};
    end else begin
      mem_valid_d   = bus.ex_valid;
      mem_ctrl_d    = gate_ctrl(ex_ctrl, bus.ex_valid);
      mem_compout_d = bus.ex_compout;
      mem_aluout_d  = bus.ex_aluout;
      mem_wdata_d   = bus.ex_wdata;
      mem_regdst_d  = bus.ex_regdst;
    end
  end

  // EX/MEM datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_valid_q   <= 1'b0;
      mem_ctrl_q    <= '{default: 1'b0};
      mem_compout_q <= 1'b0;
      mem_aluout_q  <= {DATA_W{1'b0}};
      mem_wdata_q   <= {DATA_W{1'b0}};
      mem_regdst_q  <= {REG_ADDR_W{1'b0}};
    end else begin
      mem_valid_q   <= mem_valid_d;
      mem_ctrl_q    <= mem_ctrl_d;
      mem_compout_q <= mem_compout_d;
      mem_aluout_q  <= mem_aluout_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_regdst_q  <= mem_regdst_d;
    end
  end

  assign bus.mem_valid    = mem_valid_q;
  assign bus.mem_aluout   = mem_aluout_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.mem_compout  = mem_compout_q;
  assign bus.mem_regdst   = mem_regdst_q;
  assign bus.mem_regwrite = mem_ctrl_q.regwrite;
  assign bus.mem_memread  = mem_ctrl_q.memread;
  assign bus.mem_memwrite = mem_ctrl_q.memwrite;
  assign bus.mem_memtoreg = mem_ctrl_q.memtoreg;

endmodule
